aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
- Sequencer for the AES key-expansion datapath (aes_key_expand). Owns the 256-bit full-key register and drives the expander's op/step/clear/round/key_len inputs.
- Serves round keys to the cipher core over a valid/ready handshake, one key per round.
- For decryption, first runs a forward pre-expansion so the first served key is the last encryption round key.
- Sits between the AES control FSM (start/clear) and the cipher round datapath.

Parameters:
- AES192Enable, 1, AES-192 support; when 0, key_len 3'b010 is rejected as an error.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  start request; accepted only while ready_o=1.
- ready_o  out  1  idle and able to accept start_i.
- op_i  in  1  0=encrypt (CIPH_FWD), 1=decrypt (CIPH_INV); sampled on start.
- key_len_i  in  3  one-hot: 001=128, 010=192, 100=256; sampled on start.
- key_i  in  256  initial key; sampled on start.
- clear_i  in  1  abort and wipe; highest priority.
- exp_op_o  out  1  op to the expander.
- exp_step_o  out  1  expander step strobe.
- exp_clear_o  out  1  expander rcon clear strobe.
- exp_round_o  out  4  round index to the expander.
- exp_key_len_o  out  3  latched key_len.
- exp_key_o  out  256  full-key register (key_q) to the expander.
- exp_key_i  in  256  expander result.
- rk_valid_o  out  1  round key valid.
- rk_ready_i  in  1  consumer accepts the round key.
- rk_o  out  128  key_q[127:0].
- rk_round_o  out  4  index of the key being served, 0..Nr.
- done_o  out  1  one-cycle pulse after the last round key is accepted.
- err_o  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Nr = 10/12/14 for 128/192/256. round_q is 4 bits and equals exp_round_o and rk_round_o.
- Reset: state IDLE, key_q=0, round_q=0, op/len regs=0. ready_o=1; all other outputs 0.
- States: IDLE, INIT, DEC_FWD, DEC_SWITCH, SERVE.
- IDLE: ready_o=1.
  - start_i with a valid key_len: key_q<=key_i, latch op and len, round_q<=0, go to INIT.
  - start_i with an invalid key_len (not one-hot, or 192 with AES192Enable=0): err_o=1 next cycle, stay in IDLE, registers unchanged.
- INIT (1 cycle): exp_clear_o=1, exp_op_o=FWD. Next state is SERVE if op=ENC, DEC_FWD if op=DEC.
- DEC_FWD: every cycle exp_step_o=1, exp_op_o=FWD, key_q<=exp_key_i, round_q++. After the step issued with round_q=Nr-1: round_q<=0, go to DEC_SWITCH.
- DEC_SWITCH (1 cycle): exp_clear_o=1, exp_op_o=INV, then go to SERVE.
- SERVE: rk_valid_o=1, exp_op_o=latched op.
  - Handshake (rk_valid_o & rk_ready_i) with round_q<Nr: exp_step_o=1 in the same cycle (combinational), key_q<=exp_key_i, round_q++.
  - Handshake with round_q=Nr: no step, go to IDLE, done_o=1 next cycle, key_q<=0.
- No handshake: rk_o and rk_round_o stay stable; exp_step_o=0.
- Latency from start acceptance (cycle 0) to first rk_valid_o: ENC cycle 2; DEC cycle Nr+3.
- Total keys served per operation: Nr+1.
- exp_step_o and exp_clear_o are never asserted together.
- clear_i, any state: next state IDLE, key_q<=0, round_q<=0. exp_clear_o=1 in that cycle; no step; rk_valid_o drops next cycle; no done_o.
  - clear_i wins over a simultaneous start_i or handshake.
- Asynchronous reset mid-operation returns everything to reset values immediately.

Test Plan:
- AES-128 encrypt, FIPS-197 key 000102..0f: rk_valid_o high 2 cycles after start; rk_round_o runs 0..10 with rk_ready_i=1 throughout. rk 10 = 13111d7f e3944a17 f307a78b 4d2b30c5. done_o pulses 1 cycle after round 10 is accepted; exactly 11 handshakes.
- AES-128 decrypt, same key: rk_valid_o high 13 cycles after start. First rk = 13111d7f..4d2b30c5, last rk (round 10) = 00010203..0c0d0e0f. Exactly 10 exp_step_o pulses during pre-expansion.
- AES-256 encrypt with random rk_ready_i back-pressure (50%): 15 keys served, each held stable while ready is low; all keys match the golden model.
- clear_i asserted in DEC_FWD (round_q=5) for AES-192: exp_clear_o=1 that cycle, back in IDLE with key_q=0 and ready_o=1 next cycle, no done_o. A following start proceeds normally.
- start_i with key_len=3'b011: err_o pulses once, ready_o stays 1, no exp_* activity. With AES192Enable=0, key_len=3'b010 also gives an err_o pulse.
- rst_ni deasserted asynchronously during SERVE: rk_valid_o=0, ready_o=1, key_q=0 immediately.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : aes_key_sched_ctrl
// Brief   : Sequences the AES key expander and serves one round key per round
//           to the cipher core over a valid/ready handshake.
// Rev     : 1.0  initial release
// ============================================================================

module aes_key_sched_ctrl #(
    parameter bit AES192Enable = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    output logic         ready_o,
    input  logic         op_i,
    input  logic [2:0]   key_len_i,
    input  logic [255:0] key_i,
    input  logic         clear_i,
    output logic         exp_op_o,
    output logic         exp_step_o,
    output logic         exp_clear_o,
    output logic [3:0]   exp_round_o,
    output logic [2:0]   exp_key_len_o,
    output logic [255:0] exp_key_o,
    input  logic [255:0] exp_key_i,
    output logic         rk_valid_o,
    input  logic         rk_ready_i,
    output logic [127:0] rk_o,
    output logic [3:0]   rk_round_o,
    output logic         done_o,
    output logic         err_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INIT       = 3'd1,
        DEC_FWD    = 3'd2,
        DEC_SWITCH = 3'd3,
        SERVE      = 3'd4
    } state_e;

    localparam logic c_CIPH_FWD = 1'b0;
    localparam logic c_CIPH_INV = 1'b1;

    state_e         r_state, w_state_d;
    logic [255:0]   r_key, w_key_d;
    logic [3:0]     r_round, w_round_d;
    logic           r_op, w_op_d;
    logic [2:0]     r_len, w_len_d;
    logic           r_done, w_done_d;
    logic           r_err, w_err_d;
    logic [3:0]     w_nr;
    logic           w_len192_ok;
    logic           w_len_valid;

    if (AES192Enable) begin : g_aes192_on
        assign w_len192_ok = 1'b1;
    end else begin : g_aes192_off
        assign w_len192_ok = 1'b0;
    end

    assign w_len_valid = (key_len_i == 3'b001) || (key_len_i == 3'b100) ||
                         ((key_len_i == 3'b010) && w_len192_ok);

    assign w_nr = r_len[2] ? 4'd14 : (r_len[1] ? 4'd12 : 4'd10);

    assign exp_round_o   = r_round;
    assign rk_round_o    = r_round;
    assign exp_key_len_o = r_len;
    assign exp_key_o     = r_key;
    assign rk_o          = r_key[127:0];
    assign done_o        = r_done;
    assign err_o         = r_err;

    always_comb begin
        w_state_d   = r_state;
        w_key_d     = r_key;
        w_round_d   = r_round;
        w_op_d      = r_op;
        w_len_d     = r_len;
        w_done_d    = 1'b0;
        w_err_d     = 1'b0;
        ready_o     = 1'b0;
        rk_valid_o  = 1'b0;
        exp_step_o  = 1'b0;
        exp_clear_o = 1'b0;
        exp_op_o    = c_CIPH_FWD;

        case (r_state)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    if (w_len_valid) begin
                        w_key_d   = key_i;
                        w_op_d    = op_i;
                        w_len_d   = key_len_i;
                        w_round_d = 4'd0;
                        w_state_d = INIT;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            INIT: begin
                exp_clear_o = 1'b1;
                w_state_d   = (r_op == c_CIPH_INV) ? DEC_FWD : SERVE;
            end
            DEC_FWD: begin
                // Walk forward to the last encryption round key before serving.
                exp_step_o = 1'b1;
                w_key_d    = exp_key_i;
                if (r_round == (w_nr - 4'd1)) begin
                    w_round_d = 4'd0;
                    w_state_d = DEC_SWITCH;
                end else begin
                    w_round_d = r_round + 4'd1;
                end
            end
            DEC_SWITCH: begin
                exp_clear_o = 1'b1;
                exp_op_o    = c_CIPH_INV;
                w_state_d   = SERVE;
            end
            SERVE: begin
                rk_valid_o = 1'b1;
                exp_op_o   = r_op;
                if (rk_ready_i) begin
                    if (r_round == w_nr) begin
                        w_key_d   = '0;
                        w_round_d = 4'd0;
                        w_done_d  = 1'b1;
                        w_state_d = IDLE;
                    end else begin
                        exp_step_o = 1'b1;
                        w_key_d    = exp_key_i;
                        w_round_d  = r_round + 4'd1;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // Abort overrides any start, handshake or step decided above.
        if (clear_i) begin
            w_state_d   = IDLE;
            w_key_d     = '0;
            w_round_d   = 4'd0;
            w_op_d      = r_op;
            w_len_d     = r_len;
            w_done_d    = 1'b0;
            w_err_d     = 1'b0;
            exp_step_o  = 1'b0;
            exp_clear_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_key   <= '0;
            r_round <= 4'd0;
            r_op    <= 1'b0;
            r_len   <= 3'b000;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_key   <= w_key_d;
            r_round <= w_round_d;
            r_op    <= w_op_d;
            r_len   <= w_len_d;
            r_done  <= w_done_d;
            r_err   <= w_err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_key_sched_ctrl
// Brief   : Self-checking bench: behavioural expander plus closed-form round
//           key reference, table-driven operations and corner sequences.
// Rev     : 1.0  initial release
// ============================================================================

module tb_aes_key_sched_ctrl;

    logic         clk;
    logic         rst_ni;
    logic         start_i, op_i, clear_i, rk_ready_i;
    logic [2:0]   key_len_i;
    logic [255:0] key_i, exp_key_i;
    logic         ready_o, exp_op_o, exp_step_o, exp_clear_o;
    logic [3:0]   exp_round_o, rk_round_o;
    logic [2:0]   exp_key_len_o;
    logic [255:0] exp_key_o;
    logic         rk_valid_o, done_o, err_o;
    logic [127:0] rk_o;

    // Second instance with AES-192 disabled
    logic         start0;
    logic         ready0, d0_op, d0_step, d0_clear, d0_valid, d0_done, err0;
    logic [3:0]   d0_round, d0_rk_round;
    logic [2:0]   d0_len;
    logic [255:0] d0_key;
    logic [127:0] d0_rk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [0:255][7:0] c_sbox;

    typedef struct {
        logic       op;
        logic [2:0] klen;
        bit         rnd_ready;
        bit         fips;
        bit         exp_err;
        int         lat;
    } vec_t;

    vec_t vecs [10];

    aes_key_sched_ctrl #(.AES192Enable(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .ready_o(ready_o),
        .op_i(op_i), .key_len_i(key_len_i), .key_i(key_i), .clear_i(clear_i),
        .exp_op_o(exp_op_o), .exp_step_o(exp_step_o), .exp_clear_o(exp_clear_o),
        .exp_round_o(exp_round_o), .exp_key_len_o(exp_key_len_o), .exp_key_o(exp_key_o),
        .exp_key_i(exp_key_i), .rk_valid_o(rk_valid_o), .rk_ready_i(rk_ready_i),
        .rk_o(rk_o), .rk_round_o(rk_round_o), .done_o(done_o), .err_o(err_o)
    );

    aes_key_sched_ctrl #(.AES192Enable(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start0), .ready_o(ready0),
        .op_i(op_i), .key_len_i(key_len_i), .key_i(key_i), .clear_i(clear_i),
        .exp_op_o(d0_op), .exp_step_o(d0_step), .exp_clear_o(d0_clear),
        .exp_round_o(d0_round), .exp_key_len_o(d0_len), .exp_key_o(d0_key),
        .exp_key_i(256'd0), .rk_valid_o(d0_valid), .rk_ready_i(rk_ready_i),
        .rk_o(d0_rk), .rk_round_o(d0_rk_round), .done_o(d0_done), .err_o(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rcon(int i);
        logic [7:0] r;
        r = 8'h01;
        for (int j = 1; j < i; j++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
        return r;
    endfunction

    function automatic logic [31:0] sub_rot(logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {c_sbox[r[31:24]], c_sbox[r[23:16]], c_sbox[r[15:8]], c_sbox[r[7:0]]};
    endfunction

    function automatic logic [255:0] mval(int i);
        logic [31:0] m;
        m = 32'h9e3779b9 * i;
        return {8{m}};
    endfunction

    // Expander stand-in: real AES-128 schedule, invertible additive schedule otherwise
    function automatic logic [255:0] expand_step(logic op, logic [3:0] rnd, logic [2:0] len,
                                                 logic [255:0] k);
        logic [31:0] w0, w1, w2, w3, t;
        int nr;
        nr = len[2] ? 14 : (len[1] ? 12 : 10);
        if (len == 3'b001) begin
            w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
            if (!op) begin
                t  = sub_rot(w3) ^ {rcon(int'(rnd) + 1), 24'h0};
                w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
            end else begin
                w3 = w3 ^ w2; w2 = w2 ^ w1; w1 = w1 ^ w0;
                w0 = w0 ^ sub_rot(w3) ^ {rcon(nr - int'(rnd)), 24'h0};
            end
            return {k[255:128], w0, w1, w2, w3};
        end
        if (!op) return k + mval(int'(rnd) + 1);
        return k - mval(nr - int'(rnd));
    endfunction

    // Reference: encryption round key idx from the initial key
    function automatic logic [127:0] golden_rk(logic [2:0] len, logic [255:0] k0, int idx);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [255:0] acc;
        if (len == 3'b001) begin
            for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
            for (int i = 4; i < 44; i++) begin
                t = w[i-1];
                if (i % 4 == 0) t = sub_rot(t) ^ {rcon(i / 4), 24'h0};
                w[i] = w[i-4] ^ t;
            end
            return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
        end
        acc = k0;
        for (int i = 1; i <= idx; i++) acc = acc + mval(i);
        return acc[127:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    always @(exp_op_o or exp_round_o or exp_key_len_o or exp_key_o)
        exp_key_i = expand_step(exp_op_o, exp_round_o, exp_key_len_o, exp_key_o);

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic op, input logic [2:0] klen, input logic [255:0] key);
        start_i = 1'b1; op_i = op; key_len_i = klen; key_i = key;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!rk_valid_o && n < 40) begin @(posedge clk); #1; n++; end
        chk(name, rk_valid_o, 1);
    endtask

    task automatic run_op(input vec_t v, input logic [255:0] key,
                          output logic [127:0] first_rk, output logic [127:0] last_rk);
        int nr, cyc, lat, served, steps, clears, last_hs;
        bit done_seen, held;
        logic [127:0] hold_rk;
        logic [3:0]   hold_rnd;
        logic [2:0]   len_before;
        nr = (v.klen == 3'b100) ? 14 : ((v.klen == 3'b010) ? 12 : 10);
        first_rk = '0; last_rk = '0;
        len_before = exp_key_len_o;
        start_i = 1'b1; op_i = v.op; key_len_i = v.klen; key_i = key; rk_ready_i = 1'b0;
        @(negedge clk);
        chk("start_ready", ready_o, 1);
        @(posedge clk); #1;
        start_i = 1'b0; op_i = 1'($urandom); key_len_i = 3'($urandom); key_i = rand256();
        if (v.exp_err) begin
            @(negedge clk);
            chk("err_pulse", err_o, 1);
            chk("err_ready", ready_o, 1);
            chk("err_no_exp", {exp_step_o, exp_clear_o, rk_valid_o}, 0);
            chk("err_len_kept", exp_key_len_o, len_before);
            @(posedge clk); #1;
            @(negedge clk);
            chk("err_single", err_o, 0);
            @(posedge clk); #1;
            return;
        end
        cyc = 1; lat = -1; served = 0; steps = 0; clears = 0; last_hs = -10;
        done_seen = 0; held = 0; hold_rk = '0; hold_rnd = '0;
        while (!done_seen && cyc < 100) begin
            rk_ready_i = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            chk("step_clear_excl", exp_step_o & exp_clear_o, 0);
            if (!rk_valid_o && lat < 0) begin
                steps  += int'(exp_step_o);
                clears += int'(exp_clear_o);
            end
            if (rk_valid_o) begin
                if (lat < 0) begin
                    lat = cyc;
                    chk("first_valid_latency", lat, v.lat);
                end
                if (held) begin
                    chk("hold_rk", rk_o, hold_rk);
                    chk("hold_round", rk_round_o, hold_rnd);
                end
                chk("serve_step", exp_step_o, (rk_ready_i && served < nr));
                if (rk_ready_i) begin
                    chk("rk_value", rk_o, golden_rk(v.klen, key, v.op ? nr - served : served));
                    chk("rk_round", rk_round_o, served);
                    if (served == 0) first_rk = rk_o;
                    last_rk = rk_o;
                    served++;
                    last_hs = cyc;
                    held = 0;
                end else begin
                    held = 1; hold_rk = rk_o; hold_rnd = rk_round_o;
                end
            end
            if (done_o) begin
                done_seen = 1;
                chk("done_timing", cyc, last_hs + 1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        rk_ready_i = 1'b0;
        chk("done_seen", done_seen, 1);
        chk("keys_served", served, nr + 1);
        chk("pre_steps", steps, v.op ? nr : 0);
        chk("pre_clears", clears, v.op ? 2 : 1);
        @(negedge clk);
        chk("done_single", done_o, 0);
        chk("idle_after", ready_o, 1);
        chk("key_wiped", exp_key_o, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [127:0] frk, lrk;
        logic [255:0] key;
        int n;
        c_sbox = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
                  128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
                  128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
                  128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
                  128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
                  128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
                  128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
                  128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        //            op    klen    rnd   fips  err   lat
        vecs[0] = '{1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 2};
        vecs[1] = '{1'b1, 3'b001, 1'b0, 1'b1, 1'b0, 13};
        vecs[2] = '{1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 2};
        vecs[3] = '{1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 17};
        vecs[4] = '{1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 2};
        vecs[5] = '{1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 15};
        vecs[6] = '{1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 13};
        vecs[7] = '{1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 0};
        vecs[8] = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 0};
        vecs[9] = '{1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 0};

        rst_ni = 1'b0; start_i = 1'b0; start0 = 1'b0; op_i = 1'b0; clear_i = 1'b0;
        rk_ready_i = 1'b0; key_len_i = 3'b000; key_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", rk_valid_o, 0);
        chk("rst_done_err", {done_o, err_o}, 0);
        chk("rst_step_clear_op", {exp_step_o, exp_clear_o, exp_op_o}, 0);
        chk("rst_key", exp_key_o, 0);
        chk("rst_len", exp_key_len_o, 0);
        chk("rst_round", rk_round_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            key = vecs[i].fips ? 256'h000102030405060708090a0b0c0d0e0f : rand256();
            run_op(vecs[i], key, frk, lrk);
            if (vecs[i].fips && !vecs[i].op)
                chk("fips_enc_rk10", lrk, 128'h13111d7fe3944a17f307a78b4d2b30c5);
            if (vecs[i].fips && vecs[i].op) begin
                chk("fips_dec_first", frk, 128'h13111d7fe3944a17f307a78b4d2b30c5);
                chk("fips_dec_last", lrk, 128'h000102030405060708090a0b0c0d0e0f);
            end
        end

        // Abort during AES-192 decrypt pre-expansion at round 5
        start_op(1'b1, 3'b010, rand256());
        n = 0;
        while (!(exp_step_o && exp_round_o == 4'd5) && n < 40) begin @(posedge clk); #1; n++; end
        chk("reach_round5", {exp_step_o, exp_round_o}, {1'b1, 4'd5});
        clear_i = 1'b1;
        @(negedge clk);
        chk("clr_exp_clear", exp_clear_o, 1);
        chk("clr_no_step", exp_step_o, 0);
        @(posedge clk); #1;
        clear_i = 1'b0;
        @(negedge clk);
        chk("clr_ready", ready_o, 1);
        chk("clr_key_zero", exp_key_o, 0);
        chk("clr_round_zero", exp_round_o, 0);
        chk("clr_no_valid_done", {rk_valid_o, done_o}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("clr_no_late_done", done_o, 0);
        @(posedge clk); #1;
        run_op(vecs[4], rand256(), frk, lrk);

        // Abort wins over a simultaneous start
        start_i = 1'b1; op_i = 1'b0; key_len_i = 3'b001; key_i = rand256(); clear_i = 1'b1;
        @(negedge clk);
        chk("clrstart_exp_clear", exp_clear_o, 1);
        @(posedge clk); #1;
        start_i = 1'b0; clear_i = 1'b0;
        @(negedge clk);
        chk("clrstart_idle", ready_o, 1);
        chk("clrstart_no_init", {exp_clear_o, err_o}, 0);
        chk("clrstart_key", exp_key_o, 0);
        @(posedge clk); #1;

        // Abort wins over a handshake in SERVE
        start_op(1'b0, 3'b100, rand256());
        wait_valid("serve_reached");
        rk_ready_i = 1'b1; clear_i = 1'b1;
        @(negedge clk);
        chk("clrhs_no_step", exp_step_o, 0);
        chk("clrhs_exp_clear", exp_clear_o, 1);
        @(posedge clk); #1;
        rk_ready_i = 1'b0; clear_i = 1'b0;
        @(negedge clk);
        chk("clrhs_valid_drop", rk_valid_o, 0);
        chk("clrhs_no_done", done_o, 0);
        chk("clrhs_ready", ready_o, 1);
        @(posedge clk); #1;

        // Asynchronous reset mid-SERVE takes effect without a clock edge
        start_op(1'b0, 3'b001, rand256());
        wait_valid("serve_reached_rst");
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", rk_valid_o, 0);
        chk("arst_ready", ready_o, 1);
        chk("arst_key", exp_key_o, 0);
        chk("arst_round", rk_round_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // AES-192 rejected when disabled
        start0 = 1'b1; key_len_i = 3'b010; op_i = 1'b0; key_i = rand256();
        @(posedge clk); #1;
        start0 = 1'b0;
        @(negedge clk);
        chk("no192_err", err0, 1);
        chk("no192_ready", ready0, 1);
        chk("no192_no_exp", {d0_step, d0_clear, d0_valid}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("no192_err_single", err0, 0);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
